// File: rtl/view_compositor_pkg.sv
// Shared types and helper predicates for the multi-view compositor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package view_comp_pkg;

    localparam int MAX_VIEWS = 8;

    typedef logic [11:0] rgb12_t;
    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    typedef struct packed {
        logic    en;
        hcount_t x0;
        hcount_t x1;
        vcount_t y0;
        vcount_t y1;
    } window_t;

    typedef struct packed {
        hcount_t h;
        vcount_t v;
        logic    hs;
        logic    vs;
        logic    blank;
    } timing_t;

    // Half-open bounds make x0 >= x1 or y0 >= y1 an empty window for free.
    function automatic logic win_hit(window_t w, hcount_t h, vcount_t v);
        return w.en && (h >= w.x0) && (h < w.x1) && (v >= w.y0) && (v < w.y1);
    endfunction

    function automatic logic on_border(window_t w, hcount_t h, vcount_t v);
        return (h == w.x0) || (h == w.x1 - 11'd1) || (v == w.y0) || (v == w.y1 - 10'd1);
    endfunction

endpackage

// File: rtl/view_compositor_delay_line.sv
// Fixed-depth register delay with synchronous clear; DEPTH 0 is a wire.
// Latency: DEPTH cycles.
// Backpressure: none, advances every clock.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_dat,
    output logic [WIDTH-1:0] dly_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dly_dat = src_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= src_dat;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dly_dat = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/view_compositor.sv
// Aligns N view streams plus VGA timing to MAX_LAT, picks the lowest-index window hit per pixel.
// Latency: MAX_LAT+1 cycles from coordinates to pins. Optional border: COMPOSITOR_BORDER_EN.
// Backpressure: none, one pixel per clock; window set shadowed on aligned vsync rise.
module view_compositor
    import view_comp_pkg::*;
#(
    parameter int                        NUM_VIEWS    = 3,
    parameter logic [0:NUM_VIEWS-1][3:0] VIEW_LAT     = {4'd4, 4'd1, 4'd2},
    parameter int                        MAX_LAT      = 8,
    parameter logic [11:0]               BORDER_COLOR = 12'hFFF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [NUM_VIEWS*12-1:0]   pixel_in,
    input  logic [NUM_VIEWS-1:0]      view_en,
    input  logic [NUM_VIEWS*11-1:0]   win_x0,
    input  logic [NUM_VIEWS*11-1:0]   win_x1,
    input  logic [NUM_VIEWS*10-1:0]   win_y0,
    input  logic [NUM_VIEWS*10-1:0]   win_y1,
    input  logic [11:0]               bg_color,
    output logic [3:0]                vga_r,
    output logic [3:0]                vga_g,
    output logic [3:0]                vga_b,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic                      frame_start_out
);

    if (NUM_VIEWS < 1 || NUM_VIEWS > MAX_VIEWS) begin : g_num_err
        $error("NUM_VIEWS out of range");
    end

    timing_t                      tim_in_dat, tim_al;
    rgb12_t  [NUM_VIEWS-1:0]      view_al;
    window_t [NUM_VIEWS-1:0]      cfg_win, shadow_win;
    rgb12_t                       shadow_bg, sel;
    logic                         vs_prev, load;

    assign tim_in_dat = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in, blank: blank_in};

    delay_line #(.WIDTH($bits(timing_t)), .DEPTH(MAX_LAT)) u_tim_dly (
        .clk     (clk_in),
        .rst     (rst_in),
        .src_dat (tim_in_dat),
        .dly_dat (tim_al)
    );

    for (genvar i = 0; i < NUM_VIEWS; i++) begin : g_view
        if (int'(VIEW_LAT[i]) > MAX_LAT) begin : g_lat_err
            $error("VIEW_LAT exceeds MAX_LAT");
        end

        delay_line #(.WIDTH(12), .DEPTH(MAX_LAT - int'(VIEW_LAT[i]))) u_pix_dly (
            .clk     (clk_in),
            .rst     (rst_in),
            .src_dat (pixel_in[i*12 +: 12]),
            .dly_dat (view_al[i])
        );

        assign cfg_win[i] = '{en: view_en[i],
                              x0: win_x0[i*11 +: 11], x1: win_x1[i*11 +: 11],
                              y0: win_y0[i*10 +: 10], y1: win_y1[i*10 +: 10]};
    end

    // Loading on the aligned edge keeps geometry constant across the whole visible frame.
    assign load = tim_al.vs && !vs_prev;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_win      <= '0;
            shadow_bg       <= '0;
            vs_prev         <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            vs_prev         <= tim_al.vs;
            frame_start_out <= load;
            if (load) begin
                shadow_win <= cfg_win;
                shadow_bg  <= bg_color;
            end
        end
    end

    // Walk from highest index down so the lowest-index hit is the last write.
    always_comb begin
        sel = shadow_bg;
        for (int i = NUM_VIEWS - 1; i >= 0; i--) begin
            if (win_hit(shadow_win[i], tim_al.h, tim_al.v)) begin
`ifdef COMPOSITOR_BORDER_EN
                if (on_border(shadow_win[i], tim_al.h, tim_al.v)) begin
                    sel = BORDER_COLOR;
                end else begin
                    sel = view_al[i];
                end
`else
                sel = view_al[i];
`endif
            end
        end
        if (tim_al.blank) begin
            sel = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            vga_r  <= sel[11:8];
            vga_g  <= sel[7:4];
            vga_b  <= sel[3:0];
            vga_hs <= ~tim_al.hs;
            vga_vs <= ~tim_al.vs;
        end
    end

endmodule

// File: doc/view_compositor.md
# view_compositor

Parametrised multi-view pixel compositor on the 65 MHz VGA pixel clock. It takes raster timing from the VGA generator and N view pixel streams, each with its own fixed pipeline latency. It aligns every stream and the sync signals to one common latency and selects one view per pixel from priority-ordered rectangular windows. It then drives the registered VGA pins. Window geometry and enables are runtime inputs, shadowed once per frame so they never change mid-frame.

## Interface
- NUM_VIEWS, 3: number of view input channels, 1..8
- VIEW_LAT, {4,1,2} (packed array of 4-bit values, index 0 first): latency of each view's pixel relative to hcount_in/vcount_in
- MAX_LAT, 8: common alignment latency; elaboration error if any VIEW_LAT[i] > MAX_LAT
- BORDER_COLOR, 12'hFFF: border colour, used only with the border feature
- clk_in  in  1  65 MHz pixel clock
- rst_in  in  1  synchronous, active-high reset
- hcount_in  in  11  pixel on current line
- vcount_in  in  10  line number
- hsync_in, vsync_in, blank_in  in  1 each  active-high timing from the VGA generator
- pixel_in  in  NUM_VIEWS x 12  RGB444 per view, valid VIEW_LAT[i] cycles after its coordinates
- view_en  in  NUM_VIEWS  per-view enable
- win_x0, win_x1  in  NUM_VIEWS x 11  half-open horizontal window bounds [x0, x1)
- win_y0, win_y1  in  NUM_VIEWS x 10  half-open vertical window bounds [y0, y1)
- bg_color  in  12  colour for unblanked pixels that fall in no window
- vga_r, vga_g, vga_b  out  4 each  registered colour
- vga_hs, vga_vs  out  1 each  active-low sync (inverted input sync)
- frame_start_out  out  1  one-cycle pulse when the shadow window set updates

## Operation
- Channel i: pixel_in[i] passes through a (MAX_LAT − VIEW_LAT[i])-deep delay. Depth 0 is a wire.
- hcount, vcount, hsync, vsync and blank pass through MAX_LAT-deep delays. This point is the aligned stage.
- Shadow registers hold view_en, win_* and bg_color. They load on the rising edge of aligned vsync. frame_start_out pulses high on the cycle after the load.
- Hit test at the aligned stage, per view: en && x0 ≤ h < x1 && y0 ≤ v < y1.
  - Unsigned compare.
  - x0 ≥ x1 or y0 ≥ y1 gives an empty window, never a hit.
- Selection:
  - Lowest-index hit wins.
  - No hit gives shadow bg_color.
  - Aligned blank forces 12'h000.
- Output register: vga_r/g/b = selected[11:8]/[7:4]/[3:0]; vga_hs = ~hsync_aligned; vga_vs = ~vsync_aligned.
- Reset:
  - All delay-line and output registers clear: colour 0, vga_hs = vga_vs = 1, frame_start_out = 0.
  - Shadow registers clear, so all windows are empty. Background shows until the first aligned vsync rising edge.
- Reset mid-frame discards everything in flight. There is no partial recovery.
- Input window changes mid-frame have no visible effect until the next vsync edge.

## Timing
- Colour and sync for input coordinate (h,v) appear on the pins MAX_LAT+1 cycles after (h,v) is on hcount_in/vcount_in.
- Sync and colour are exactly co-aligned.
- Throughput is one pixel per clock, with no stalls and no handshake.
- Shadow load occurs on the cycle aligned vsync goes 0→1; frame_start_out is high on the next cycle only.
- A vsync held high loads once.
- An edge arriving during reset is not captured.

## Configuration
- COMPOSITOR_BORDER_EN defined:
  - A winning view's pixel is replaced by BORDER_COLOR when h == x0, h == x1−1, v == y0 or v == y1−1.
  - The border is drawn only for the winning window, never over a higher-priority view.
  - Latency is unchanged.
- Undefined: no border logic is generated and BORDER_COLOR is unused.

## Structure
- Package view_comp_pkg:
  - rgb12_t, hcount_t (11 b), vcount_t (10 b)
  - window_t struct {en, x0, x1, y0, y1}
  - MAX_VIEWS = 8
- Sub-module delay_line (params WIDTH, DEPTH; DEPTH 0 = passthrough). Synchronous reset to 0. Used per view and for the timing bundle.

## Test plan
- NUM_VIEWS=3, VIEW_LAT={4,1,2}, each view driving a constant colour tagged by its index, windows [0,512)x[0,512), [512,1024)x[0,384), [512,1024)x[512,768) → pixel (511,0) red from view 0, (512,0) view 1, (600,400) bg_color, (600,600) view 2; all appear exactly 9 cycles after the coordinates.
- Overlapping windows: view 0 [100,200)x[100,200), view 1 [0,1024)x[0,768) → (150,150) shows view 0; with view_en[0]=0 after the next vsync, it shows view 1.
- win_x0=300, win_x1=300 → window empty; no pixel on that view's column range selects it.
- Change win_x1 mid-frame at line 200 → output unchanged until after the next vsync rising edge; frame_start_out pulses once, one cycle after that edge.
- Assert rst_in for 3 cycles mid-line → colour 0, vga_hs=vga_vs=1, background until the next vsync, then the configured windows return.
- COMPOSITOR_BORDER_EN defined, window [100,200)x[100,200) → (100,150), (199,150), (150,100) and (150,199) are 12'hFFF; (150,150) shows the view pixel.
